// File: rtl/ea_seq_ctrl.sv
// ea_seq_ctrl: multi-cycle effective-address sequencer for a 16-bit LC-3-style datapath.
// It decodes the offset field of an instruction, sign-extends it and adds it to PC or
// BaseR. For LDI/STI it also reads the pointer word from memory.
//
// Ports:
//   Clk, Reset_n              clock (rising edge), asynchronous active-low reset
//   instr_valid/instr_ready   instruction handshake; IR and PC are captured on accept
//   sr1_addr, BaseR           regfile read address and its combinational read data
//   mem_req/mem_addr          indirect pointer read request and address
//   mem_ack/mem_rdata         pointer read data valid and data
//   ea_valid/ea_ready         result handshake
//   ea, ea_class              result; class 00 direct, 01 indirect, 10 immediate, 11 error
// Optional build macro EA_SEQ_STATS_EN adds two saturating counters:
//   done_cnt counts result handshakes, ind_cnt counts successful pointer reads.
module ea_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] IR,
  input  logic [15:0] PC,
  output logic [2:0]  sr1_addr,
  input  logic [15:0] BaseR,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        ea_valid,
  input  logic        ea_ready,
  output logic [15:0] ea,
  output logic [1:0]  ea_class
`ifdef EA_SEQ_STATS_EN
  ,
  output logic [15:0] done_cnt,
  output logic [15:0] ind_cnt
`endif
);

  localparam int unsigned DW = 16;
  localparam int unsigned TW = 8;

  localparam logic [1:0] CLS_DIR = 2'b00;
  localparam logic [1:0] CLS_IND = 2'b01;
  localparam logic [1:0] CLS_IMM = 2'b10;
  localparam logic [1:0] CLS_ERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    IND_REQ = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   pc_q, pc_d;
  logic            instr_ready_d;
  logic [2:0]      sr1_addr_d;
  logic            mem_req_d;
  logic [DW-1:0]   mem_addr_d;
  logic            ea_valid_d;
  logic [DW-1:0]   ea_d;
  logic [1:0]      ea_class_d;
  logic [TW-1:0]   tmo_cnt, tmo_cnt_d;

  // Returns true for opcodes that read a base register: LDR, STR, JMP and JSRR.
  function automatic logic uses_base(input logic [DW-1:0] ir);
    logic r;
    r = 1'b0;
    case (ir[15:12])
      4'b0110, 4'b0111, 4'b1100: r = 1'b1;
      4'b0100:                   r = ~ir[11];
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  // Sign-extended offset fields and the candidate address sums.
  logic [DW-1:0] sext5, sext6, sext9, sext11;
  logic [DW-1:0] pc_off9, pc_off11, base_off6;

  assign sext5     = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sext6     = {{10{ir_q[5]}}, ir_q[5:0]};
  assign sext9     = {{7{ir_q[8]}}, ir_q[8:0]};
  assign sext11    = {{5{ir_q[10]}}, ir_q[10:0]};
  assign pc_off9   = pc_q + sext9;
  assign pc_off11  = pc_q + sext11;
  assign base_off6 = BaseR + sext6;

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      ir_q        <= '0;
      pc_q        <= '0;
      instr_ready <= 1'b1;
      sr1_addr    <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      ea_valid    <= 1'b0;
      ea          <= '0;
      ea_class    <= CLS_DIR;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      instr_ready <= instr_ready_d;
      sr1_addr    <= sr1_addr_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      ea_valid    <= ea_valid_d;
      ea          <= ea_d;
      ea_class    <= ea_class_d;
      tmo_cnt     <= tmo_cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    ir_d       = ir_q;
    pc_d       = pc_q;
    sr1_addr_d = sr1_addr;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    ea_valid_d = ea_valid;
    ea_d       = ea;
    ea_class_d = ea_class;
    tmo_cnt_d  = tmo_cnt;

    case (state)
      IDLE: begin
        if (instr_valid) begin
          ir_d       = IR;
          pc_d       = PC;
          // Present the base register address during CALC so BaseR is settled by its end.
          sr1_addr_d = uses_base(IR) ? IR[8:6] : 3'd0;
          state_d    = CALC;
        end
      end

      CALC: begin
        tmo_cnt_d = '0;
        state_d   = OUT;
        case (ir_q[15:12])
          4'b0001, 4'b0101: begin
            ea_d       = ir_q[5] ? sext5 : '0;
            ea_class_d = CLS_IMM;
          end
          4'b1001: begin
            ea_d       = '0;
            ea_class_d = CLS_IMM;
          end
          4'b0000, 4'b0010, 4'b0011, 4'b1110: begin
            ea_d       = pc_off9;
            ea_class_d = CLS_DIR;
          end
          4'b1010, 4'b1011: begin
            mem_addr_d = pc_off9;
            mem_req_d  = 1'b1;
            state_d    = IND_REQ;
          end
          4'b0110, 4'b0111: begin
            ea_d       = base_off6;
            ea_class_d = CLS_DIR;
          end
          4'b0100: begin
            ea_d       = ir_q[11] ? pc_off11 : BaseR;
            ea_class_d = CLS_DIR;
          end
          4'b1100: begin
            ea_d       = BaseR;
            ea_class_d = CLS_DIR;
          end
          4'b1111: begin
            ea_d       = {8'h00, ir_q[7:0]};
            ea_class_d = CLS_DIR;
          end
          default: begin
            ea_d       = '0;
            ea_class_d = CLS_ERR;
          end
        endcase
        ea_valid_d = (state_d == OUT);
      end

      IND_REQ: begin
        if (mem_ack) begin
          ea_d       = mem_rdata;
          ea_class_d = CLS_IND;
          mem_req_d  = 1'b0;
          ea_valid_d = 1'b1;
          state_d    = OUT;
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          // This is the last cycle without an ack, so give up with an error result.
          tmo_cnt_d  = tmo_cnt + TW'(1);
          ea_d       = '0;
          ea_class_d = CLS_ERR;
          mem_req_d  = 1'b0;
          ea_valid_d = 1'b1;
          state_d    = OUT;
        end else begin
          tmo_cnt_d = tmo_cnt + TW'(1);
        end
      end

      OUT: begin
        if (ea_ready) begin
          ea_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    instr_ready_d = (state_d == IDLE);
  end

`ifdef EA_SEQ_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      done_cnt <= '0;
      ind_cnt  <= '0;
    end else begin
      if ((state == OUT) && ea_ready && (done_cnt != 16'hFFFF))
        done_cnt <= done_cnt + 16'd1;
      if ((state == IND_REQ) && mem_ack && (ind_cnt != 16'hFFFF))
        ind_cnt <= ind_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ea_seq_ctrl.sv
// Testbench for ea_seq_ctrl. Expected results are queued when an instruction is
// driven and are compared when the sequencer presents its result.
module tb_ea_seq_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] IR;
  logic [15:0] PC;
  logic [2:0]  sr1_addr;
  logic [15:0] BaseR;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ea_valid;
  logic        ea_ready;
  logic [15:0] ea;
  logic [1:0]  ea_class;
`ifdef EA_SEQ_STATS_EN
  logic [15:0] done_cnt;
  logic [15:0] ind_cnt;
`endif

  logic [15:0] regs [8];
  assign BaseR = regs[sr1_addr];

  ea_seq_ctrl #(.TIMEOUT_CYC(64)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .IR          (IR),
    .PC          (PC),
    .sr1_addr    (sr1_addr),
    .BaseR       (BaseR),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ea_valid    (ea_valid),
    .ea_ready    (ea_ready),
    .ea          (ea),
    .ea_class    (ea_class)
`ifdef EA_SEQ_STATS_EN
    ,
    .done_cnt    (done_cnt),
    .ind_cnt     (ind_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] ea;
    logic [1:0]  cls;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Compare the presented result against the oldest queued expectation.
  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sbq"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_ea"}, 32'(ea), 32'(e.ea));
      check({tag, "_cls"}, 32'(ea_class), 32'(e.cls));
    end
  endtask

  // Direct or immediate instruction with the downstream always ready.
  task automatic run_direct(input string tag, input logic [15:0] ir, input logic [15:0] pc,
                            input logic [2:0] exp_sr1, input logic [15:0] exp_ea,
                            input logic [1:0] exp_cls);
    check({tag, "_irdy"}, 32'(instr_ready), 32'd1);
    IR = ir; PC = pc; instr_valid = 1'b1; ea_ready = 1'b1;
    sb.push_back({exp_ea, exp_cls});
    tick();
    instr_valid = 1'b0;
    check({tag, "_sr1"}, 32'(sr1_addr), 32'(exp_sr1));
    check({tag, "_calc_v"}, 32'(ea_valid), 32'd0);
    check({tag, "_busy"}, 32'(instr_ready), 32'd0);
    tick();
    check({tag, "_lat"}, 32'(ea_valid), 32'd1);
    pop_check(tag);
    tick();
    check({tag, "_done"}, 32'(ea_valid), 32'd0);
  endtask

  // Indirect read; ack is raised in cycle ack_at of the request (0 = never).
  task automatic run_ind(input string tag, input logic [15:0] ir, input logic [15:0] pc,
                         input logic [15:0] exp_addr, input int ack_at,
                         input logic [15:0] rdata, output int req_cycles);
    int n;
    IR = ir; PC = pc; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check({tag, "_calc_req"}, 32'(mem_req), 32'd0);
    tick();
    check({tag, "_maddr"}, 32'(mem_addr), 32'(exp_addr));
    n = 0;
    for (int i = 0; i < 300 && mem_req; i++) begin
      n++;
      if (mem_addr !== exp_addr) check({tag, "_maddr_stable"}, 32'(mem_addr), 32'(exp_addr));
      if (n == ack_at) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      tick();
      mem_ack = 1'b0;
    end
    req_cycles = n;
  endtask

  int rc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h1111);
    regs[2] = 16'h3000;
    regs[4] = 16'h0001;
    regs[5] = 16'h4567;
    regs[6] = 16'h8888;
    instr_valid = 1'b0; IR = '0; PC = '0;
    mem_ack = 1'b0; mem_rdata = '0; ea_ready = 1'b0;
    Reset_n = 1'b0;
    #12;
    check("rst_irdy", 32'(instr_ready), 32'd1);
    check("rst_mreq", 32'(mem_req), 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_eav", 32'(ea_valid), 32'd0);
    check("rst_ea", 32'(ea), 32'd0);
    check("rst_cls", 32'(ea_class), 32'd0);
    check("rst_sr1", 32'(sr1_addr), 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    run_direct("ldr",      16'h6285, 16'h0000, 3'd2, 16'h3005, 2'b00);

    // BR with downstream stalled; a new instruction offered meanwhile must be ignored.
    IR = 16'h0FFE; PC = 16'h3010; instr_valid = 1'b1; ea_ready = 1'b0;
    sb.push_back({16'h300E, 2'b00});
    tick();
    instr_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("br_hold_v", 32'(ea_valid), 32'd1);
      check("br_hold_ea", 32'(ea), 32'h300E);
      check("br_hold_irdy", 32'(instr_ready), 32'd0);
      IR = 16'h1030; instr_valid = 1'b1;
      tick();
    end
    instr_valid = 1'b0; ea_ready = 1'b1;
    pop_check("br");
    tick();
    check("br_done_v", 32'(ea_valid), 32'd0);
    check("br_done_irdy", 32'(instr_ready), 32'd1);

    // LDI with ack in the third request cycle.
    ea_ready = 1'b1;
    sb.push_back({16'h4000, 2'b01});
    run_ind("ldi", 16'hA002, 16'h3000, 16'h3002, 3, 16'h4000, rc);
    check("ldi_req_cyc", 32'(rc), 32'd3);
    check("ldi_eav", 32'(ea_valid), 32'd1);
    pop_check("ldi");
    tick();
    check("ldi_done", 32'(ea_valid), 32'd0);

    run_direct("jsr_wrap", 16'h4BFF, 16'hFF00, 3'd0, 16'h02FF, 2'b00);
    run_direct("add_imm",  16'h1030, 16'h0000, 3'd0, 16'hFFF0, 2'b10);
    run_direct("and_reg",  16'h5042, 16'h0000, 3'd0, 16'h0000, 2'b10);
    run_direct("not",      16'h903F, 16'h0000, 3'd0, 16'h0000, 2'b10);
    run_direct("ldr_neg",  16'h673E, 16'h0000, 3'd4, 16'hFFFF, 2'b00);
    run_direct("jmp",      16'hC140, 16'h0000, 3'd5, 16'h4567, 2'b00);
    run_direct("jsrr",     16'h4180, 16'h1234, 3'd6, 16'h8888, 2'b00);
    run_direct("trap",     16'hF025, 16'h2000, 3'd0, 16'h0025, 2'b00);
    run_direct("st_neg",   16'h3100, 16'h0050, 3'd0, 16'hFF50, 2'b00);
    run_direct("rsvd",     16'hD000, 16'h0000, 3'd0, 16'h0000, 2'b11);

    // LDI timeout, then late acks in OUT and IDLE must have no effect.
    ea_ready = 1'b0;
    sb.push_back({16'h0000, 2'b11});
    run_ind("tmo", 16'hA002, 16'h3000, 16'h3002, 0, 16'h0000, rc);
    check("tmo_req_cyc", 32'(rc), 32'd64);
    check("tmo_eav", 32'(ea_valid), 32'd1);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    check("tmo_late_ea", 32'(ea), 32'h0000);
    check("tmo_late_cls", 32'(ea_class), 32'd3);
    check("tmo_late_req", 32'(mem_req), 32'd0);
    ea_ready = 1'b1;
    pop_check("tmo");
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_v", 32'(ea_valid), 32'd0);
    check("idle_ack_req", 32'(mem_req), 32'd0);
    check("idle_ack_irdy", 32'(instr_ready), 32'd1);

    run_direct("rti",      16'h8000, 16'h0000, 3'd0, 16'h0000, 2'b11);

    // Asynchronous reset in the middle of a pointer read.
    IR = 16'hA002; PC = 16'h3000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("rstm_req_pre", 32'(mem_req), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("rstm_req", 32'(mem_req), 32'd0);
    check("rstm_irdy", 32'(instr_ready), 32'd1);
    check("rstm_maddr", 32'(mem_addr), 32'd0);
    check("rstm_eav", 32'(ea_valid), 32'd0);
    sb.delete();
    tick();
    Reset_n = 1'b1;
    tick();
    run_direct("lea",      16'hE005, 16'h1000, 3'd0, 16'h1005, 2'b00);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
